inst_mem_loader: RTL and testbench



---
 rtl/inst_mem_loader_pkg.sv | 24 ++
 rtl/inst_mem_loader_if.sv | 27 ++
 rtl/inst_mem_loader_word_assembler.sv | 30 +++
 rtl/inst_mem_loader.sv | 160 ++++++++++++++++
 tb/tb_inst_mem_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Sizes mirror the instruction memory geometry and the core datapath width.
// The loader timeout default is sized for a slow UART front end.
package inst_mem_loader_pkg;

  localparam int CPU_WIDTH           = 32;
  localparam int INST_MEM_ADDR_WIDTH = 8;
  localparam int INST_MEM_ADDR_DEPTH = 256;
  localparam int LOADER_TIMEOUT_CYC  = 1000000;

  // Image header carries a 16-bit little-endian word count.
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// slave is the loader's view; master is the front end / memory side.
// Byte stream uses valid/ready; the memory write is a one-cycle strobe.
interface inst_mem_loader_if
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W = INST_MEM_ADDR_WIDTH
);

  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 imem_we;
  logic [ADDR_W-1:0]    imem_waddr;
  logic [CPU_WIDTH-1:0] imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/inst_mem_loader_word_assembler.sv
// Collects the three low bytes of a little-endian word and tracks byte index.
// Zero latency: the fourth byte is merged by the caller on its accept cycle.
// No backpressure of its own; it advances only when load is asserted.
module inst_mem_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_data,
  output logic [1:0]  idx,
  output logic [23:0] lo_bytes
);

  // Byte index wraps 0..3; bytes 0..2 are parked at bits [8i+7:8i].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= 2'd0;
      lo_bytes <= 24'd0;
    end else if (clr) begin
      idx      <= 2'd0;
      lo_bytes <= 24'd0;
    end else if (load) begin
      idx <= idx + 2'd1;
      if (idx != 2'd3) begin
        lo_bytes[{idx, 3'b000} +: 8] <= byte_data;
      end
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length/checksum-framed byte image into instruction memory.
// Memory write lands 1 cycle after the 4th byte of each word is accepted.
// byte_ready is a registered function of state; no dependence on byte_valid.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W      = INST_MEM_ADDR_WIDTH,
  parameter int DEPTH       = INST_MEM_ADDR_DEPTH,
  parameter int TIMEOUT_CYC = LOADER_TIMEOUT_CYC,
  parameter bit BOOT_HOLD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  inst_mem_loader_if.slave bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // One extra bit so a full-depth image (N == DEPTH) counts without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  loader_state_t    state;
  logic [CNT_W-1:0] word_cnt;
  logic [LEN_W-1:0] len;
  logic [7:0]       csum;
  logic [TO_W-1:0]  idle_cnt;

  logic             accept;
  logic             launch;
  logic             load;
  logic             last_word;
  logic             timeout;
  logic [LEN_W-1:0] n;
  logic [1:0]       idx;
  logic [23:0]      lo_bytes;

  assign accept    = bus.byte_valid && bus.byte_ready;
  assign launch    = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign load      = accept && (state == DATA);
  assign n         = {bus.byte_data, len[7:0]};
  assign last_word = (word_cnt == CNT_W'(len - LEN_W'(1)));
  // An accept on the expiry cycle keeps the session alive.
  assign timeout   = busy && !accept && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  inst_mem_loader_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (launch),
    .load      (load),
    .byte_data (bus.byte_data),
    .idx       (idx),
    .lo_bytes  (lo_bytes)
  );

  // Session FSM with registered handshake, memory-write and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      cpu_hold       <= BOOT_HOLD;
      word_cnt       <= '0;
      len            <= '0;
      csum           <= '0;
      idle_cnt       <= '0;
    end else begin
      bus.imem_we <= 1'b0;

      if (accept) begin
        csum     <= csum ^ bus.byte_data;
        idle_cnt <= '0;
      end else if (busy) begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end

      case (state)
        IDLE, DONE, ERR: begin
          if (launch) begin
            state          <= LEN_LO;
            bus.byte_ready <= 1'b1;
            busy           <= 1'b1;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            word_cnt       <= '0;
            csum           <= '0;
            idle_cnt       <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.byte_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= bus.byte_data;
            if (n == '0) begin
              state <= CSUM;
            end else if (int'(n) > DEPTH) begin
              state          <= ERR;
              bus.byte_ready <= 1'b0;
              busy           <= 1'b0;
              err            <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (load && (idx == 2'd3)) begin
            bus.imem_we    <= 1'b1;
            bus.imem_waddr <= word_cnt[ADDR_W-1:0];
            bus.imem_wdata <= {bus.byte_data, lo_bytes};
            word_cnt       <= word_cnt + CNT_W'(1);
            if (last_word) begin
              state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            if ((csum ^ bus.byte_data) == 8'd0) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Stalled stream: abandon the session and keep the core held.
      if (timeout) begin
        state          <= ERR;
        bus.byte_ready <= 1'b0;
        busy           <= 1'b0;
        err            <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader.
// Expected memory writes are queued when a stream is driven and popped on imem_we.
// Status levels are compared after each session finishes.
module tb_inst_mem_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  logic start;
  logic cpu_hold;
  logic busy;
  logic done;
  logic err;

  int n_chk;
  int n_fail;
  int wr_cnt;
  wr_t exp_q[$];

  inst_mem_loader_if #(.ADDR_W(8)) bus ();

  inst_mem_loader #(
    .ADDR_W      (8),
    .DEPTH       (256),
    .TIMEOUT_CYC (16),
    .BOOT_HOLD   (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_t e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.imem_waddr), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 64'(bus.imem_waddr), 64'(e.addr));
        check("wdata", 64'(bus.imem_wdata), 64'(e.data));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Holds valid until the byte is taken on a rising edge; returns 1 time unit later.
  task automatic send_byte(input logic [7:0] b);
    bit took;
    took = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int t = 0; t < 20 && !took; t++) begin
      @(negedge clk);
      took = bus.byte_ready;
      @(posedge clk); #1;
    end
    if (!took) check("ready_wait", 64'd0, 64'd1);
  endtask

  // Back-to-back stream; with lat set, each word's write must be visible right after its 4th byte.
  task automatic send_stream(input logic [7:0] q[$], input bit lat);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (lat && i >= 5 && ((i - 5) % 4) == 0 && i < q.size() - 1)
        check("write_latency", 64'(bus.imem_we), 64'd1);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_fin();
    int t;
    t = 0;
    while (!(done || err) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!(done || err)) check("session_end_wait", 64'd0, 64'd1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    check({pfx, "_imem_we"},    64'(bus.imem_we),    64'd0);
    check({pfx, "_imem_waddr"}, 64'(bus.imem_waddr), 64'd0);
    check({pfx, "_imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
    check({pfx, "_busy"},       64'(busy),           64'd0);
    check({pfx, "_done"},       64'(done),           64'd0);
    check({pfx, "_err"},        64'(err),            64'd0);
    check({pfx, "_cpu_hold"},   64'(cpu_hold),       64'd1);
  endtask

  task automatic push_nominal();
    exp_q.push_back('{addr: 8'd0, data: 32'h0050_0093});
    exp_q.push_back('{addr: 8'd1, data: 32'h00A0_0113});
  endtask

  initial begin
    logic [7:0] nominal[$];
    logic [7:0] bad_cs[$];
    logic [7:0] empty[$];
    int wr0;
    int cyc;

    nominal = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    bad_cs  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h72};
    empty   = '{8'h00, 8'h00, 8'h00};

    n_chk = 0;
    n_fail = 0;
    wr_cnt = 0;
    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("reset");

    // Nominal two-word image.
    push_nominal();
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(bus.byte_ready), 64'd1);
    send_stream(nominal, 1'b1);
    wait_fin();
    check("nom_done", 64'(done), 64'd1);
    check("nom_err", 64'(err), 64'd0);
    check("nom_hold", 64'(cpu_hold), 64'd0);
    check("nom_busy", 64'(busy), 64'd0);
    check("nom_ready", 64'(bus.byte_ready), 64'd0);
    check("nom_writes", 64'(wr_cnt), 64'd2);

    // Same image, corrupted checksum byte.
    push_nominal();
    pulse_start();
    send_stream(bad_cs, 1'b0);
    wait_fin();
    check("badcs_err", 64'(err), 64'd1);
    check("badcs_done", 64'(done), 64'd0);
    check("badcs_hold", 64'(cpu_hold), 64'd1);
    check("badcs_writes", 64'(wr_cnt), 64'd4);

    // Zero-length image.
    wr0 = wr_cnt;
    pulse_start();
    send_stream(empty, 1'b0);
    wait_fin();
    check("empty_done", 64'(done), 64'd1);
    check("empty_err", 64'(err), 64'd0);
    check("empty_hold", 64'(cpu_hold), 64'd0);
    check("empty_writes", 64'(wr_cnt - wr0), 64'd0);

    // Length DEPTH+1 = 257 rejected right after the high length byte.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    bus.byte_valid = 1'b0;
    check("over_err", 64'(err), 64'd1);
    check("over_ready", 64'(bus.byte_ready), 64'd0);
    check("over_busy", 64'(busy), 64'd0);
    check("over_hold", 64'(cpu_hold), 64'd1);
    repeat (3) @(posedge clk);
    #1 check("over_writes", 64'(wr_cnt - wr0), 64'd0);

    // Stall after three data bytes; a start pulse mid-stall must not restart the session.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    bus.byte_valid = 1'b0;
    cyc = 0;
    while (!err && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) start = 1'b1;
      if (cyc == 6) start = 1'b0;
    end
    check("timeout_cycles", 64'(cyc), 64'd16);
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_busy", 64'(busy), 64'd0);
    check("timeout_hold", 64'(cpu_hold), 64'd1);
    check("timeout_writes", 64'(wr_cnt - wr0), 64'd0);

    // Asynchronous reset in the middle of DATA, then a clean reload.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals("arst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    push_nominal();
    pulse_start();
    send_stream(nominal, 1'b1);
    wait_fin();
    check("reload_done", 64'(done), 64'd1);
    check("reload_err", 64'(err), 64'd0);
    check("reload_hold", 64'(cpu_hold), 64'd0);

    repeat (2) @(posedge clk);
    #1 check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
